// File: rtl/lcd_arbiter_seq_if.sv
// lcd_arbiter_seq_if
// Bundles the two requester handshakes, the byte-writer handshake and the
// status outputs of lcd_arbiter_seq.
//   r0_*/r1_*  : requester byte channels (req/rs/data/last in, ack out)
//   wr_*       : byte-writer engine (start/rs/data out, busy/done in)
//   ready      : init done and arbiter idle
//   owner      : current or last granted requester
// slave  = arbiter side, master = requesters + writer side.
interface lcd_arbiter_seq_if;
    logic       r0_req;
    logic       r0_rs;
    logic [7:0] r0_data;
    logic       r0_last;
    logic       r0_ack;
    logic       r1_req;
    logic       r1_rs;
    logic [7:0] r1_data;
    logic       r1_last;
    logic       r1_ack;
    logic       wr_start;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_busy;
    logic       wr_done;
    logic       ready;
    logic       owner;

    modport slave (
        input  r0_req, r0_rs, r0_data, r0_last,
        output r0_ack,
        input  r1_req, r1_rs, r1_data, r1_last,
        output r1_ack,
        output wr_start, wr_rs, wr_data,
        input  wr_busy, wr_done,
        output ready, owner
    );

    modport master (
        output r0_req, r0_rs, r0_data, r0_last,
        input  r0_ack,
        output r1_req, r1_rs, r1_data, r1_last,
        input  r1_ack,
        input  wr_start, wr_rs, wr_data,
        output wr_busy, wr_done,
        input  ready, owner
    );
endinterface

// File: rtl/lcd_arbiter_seq.sv
// lcd_arbiter_seq
// Front end for the LCD byte writer: runs the HD44780 power-up init sequence
// after reset, then shares the writer between two requesters using
// round-robin arbitration with packet locking. Clear/home instructions get
// their post-command wait inserted before the requester is acked.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active low
//   bus    : lcd_arbiter_seq_if.slave (requesters, writer, ready, owner)
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_PWRUP      | power-up wait before the first init command
// S_INIT_ISSUE | pulse wr_start with the current init table entry
// S_INIT_WAIT  | wait for wr_done of the init byte
// S_INIT_DLY   | wait after the init clear command
// S_IDLE       | ready; arbitrate between requesters
// S_ISSUE      | pulse wr_start for the latched byte (or, locked, wait
//              | for the owner's next byte)
// S_WAIT_DONE  | wait for wr_done of a requester byte
// S_CLR_DLY    | wait after a clear/home command before acking
module lcd_arbiter_seq #(
    parameter int WAIT_POWERUP = 750000,
    parameter int WAIT_CLEAR   = 82000,
    parameter int CNT_W        = 20
) (
    input  logic               clk,
    input  logic               reset,
    lcd_arbiter_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_INIT_DLY,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_CLR_DLY
    } state_t;

    localparam logic [CNT_W-1:0] PWR_TC = CNT_W'(WAIT_POWERUP - 1);
    localparam logic [CNT_W-1:0] CLR_TC = CNT_W'(WAIT_CLEAR - 1);

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       idx_q, idx_n;
    logic             lock_q, lock_n;
    logic             pend_q, pend_n;
    logic             lat_rs_q, lat_rs_n;
    logic [7:0]       lat_data_q, lat_data_n;
    logic             lat_last_q, lat_last_n;
    logic             owner_q, owner_n;
    logic             last_grant_q, last_grant_n;
    logic             ack0_q, ack0_n;
    logic             ack1_q, ack1_n;

    logic       start;
    logic       take;
    logic       take_sel;
    logic       finish;
    logic       eff0, eff1;
    logic       arb_any, arb_sel;
    logic [7:0] init_byte;
    logic       init_phase;
    logic       is_clr;

    always_comb begin
        case (idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    end

    // A requester still sees its ack cycle with req high; mask it so the
    // just-finished byte is not granted a second time.
    assign eff0    = bus.r0_req & ~ack0_q;
    assign eff1    = bus.r1_req & ~ack1_q;
    assign arb_any = eff0 | eff1;
    assign arb_sel = eff1 & (~eff0 | ~last_grant_q);

    assign is_clr = ~lat_rs_q & ((lat_data_q == 8'h01) | (lat_data_q == 8'h02));

    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        idx_n        = idx_q;
        lock_n       = lock_q;
        pend_n       = pend_q;
        owner_n      = owner_q;
        last_grant_n = last_grant_q;
        lat_rs_n     = lat_rs_q;
        lat_data_n   = lat_data_q;
        lat_last_n   = lat_last_q;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        start        = 1'b0;
        take         = 1'b0;
        take_sel     = 1'b0;
        finish       = 1'b0;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_TC) begin
                    state_n = S_INIT_ISSUE;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_INIT_ISSUE: begin
                if (!bus.wr_busy) begin
                    start   = 1'b1;
                    state_n = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (bus.wr_done) begin
                    if (init_byte == 8'h01) begin
                        state_n = S_INIT_DLY;
                        cnt_n   = '0;
                    end else begin
                        idx_n   = idx_q + 1'b1;
                        state_n = S_INIT_ISSUE;
                    end
                end
            end
            S_INIT_DLY: begin
                if (cnt_q == CLR_TC) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (arb_any) begin
                    take     = 1'b1;
                    take_sel = arb_sel;
                    state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pend_q) begin
                    if (!bus.wr_busy) begin
                        start   = 1'b1;
                        pend_n  = 1'b0;
                        state_n = S_WAIT_DONE;
                    end
                end else if (lock_q) begin
                    // Mid-packet: only the owner may supply the next byte.
                    if (owner_q ? eff1 : eff0) begin
                        take     = 1'b1;
                        take_sel = owner_q;
                    end
                end else if (arb_any) begin
                    take     = 1'b1;
                    take_sel = arb_sel;
                end
            end
            S_WAIT_DONE: begin
                if (bus.wr_done) begin
                    if (is_clr) begin
                        state_n = S_CLR_DLY;
                        cnt_n   = '0;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_CLR_DLY: begin
                if (cnt_q == CLR_TC) begin
                    finish = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = S_PWRUP;
        endcase

        if (take) begin
            pend_n       = 1'b1;
            owner_n      = take_sel;
            last_grant_n = take_sel;
            lat_rs_n     = take_sel ? bus.r1_rs   : bus.r0_rs;
            lat_data_n   = take_sel ? bus.r1_data : bus.r0_data;
            lat_last_n   = take_sel ? bus.r1_last : bus.r0_last;
        end

        if (finish) begin
            ack0_n = ~owner_q;
            ack1_n = owner_q;
            if (lat_last_q) begin
                lock_n  = 1'b0;
                state_n = S_IDLE;
            end else begin
                lock_n  = 1'b1;
                state_n = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_PWRUP;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            lock_q       <= 1'b0;
            pend_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lat_rs_q     <= 1'b0;
            lat_data_q   <= 8'h00;
            lat_last_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            idx_q        <= idx_n;
            lock_q       <= lock_n;
            pend_q       <= pend_n;
            owner_q      <= owner_n;
            last_grant_q <= last_grant_n;
            lat_rs_q     <= lat_rs_n;
            lat_data_q   <= lat_data_n;
            lat_last_q   <= lat_last_n;
            ack0_q       <= ack0_n;
            ack1_q       <= ack1_n;
        end
    end

    assign init_phase   = (state_q == S_INIT_ISSUE) || (state_q == S_INIT_WAIT);
    assign bus.wr_start = start;
    assign bus.wr_rs    = init_phase ? 1'b0 : lat_rs_q;
    assign bus.wr_data  = init_phase ? init_byte : lat_data_q;
    assign bus.ready    = (state_q == S_IDLE);
    assign bus.owner    = owner_q;
    assign bus.r0_ack   = ack0_q;
    assign bus.r1_ack   = ack1_q;

endmodule

// File: tb/tb_lcd_arbiter_seq.sv
// tb_lcd_arbiter_seq
// Directed bench for lcd_arbiter_seq with short waits (20 / 10 cycles) and a
// writer model that stays busy 5 cycles after wr_start, then pulses wr_done.
module tb_lcd_arbiter_seq;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   viol;
    int   starts;
    logic [8:0] log_q[$];

    lcd_arbiter_seq_if bus();

    lcd_arbiter_seq #(
        .WAIT_POWERUP(20),
        .WAIT_CLEAR  (10),
        .CNT_W       (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Writer engine model
    initial begin
        bus.wr_busy = 1'b0;
        bus.wr_done = 1'b0;
        starts = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_start) begin
                starts++;
                log_q.push_back({bus.wr_rs, bus.wr_data});
                @(posedge clk); #1;
                bus.wr_busy = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                bus.wr_busy = 1'b0;
                bus.wr_done = 1'b1;
                @(posedge clk); #1;
                bus.wr_done = 1'b0;
            end
        end
    end

    // Protocol monitor
    initial begin
        viol = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_start && bus.wr_busy) viol++;
            if (bus.r0_ack && bus.r1_ack) viol++;
        end
    end

    // Wait (from just after an edge) for a byte transfer and its ack.
    task automatic serve(input logic r, input logic rs, input logic [7:0] d, input string tag);
        int n;
        n = 0;
        while (!bus.wr_start && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_start"}, bus.wr_start, 1);
        chk({tag, "_byte"}, {bus.wr_rs, bus.wr_data}, {rs, d});
        chk({tag, "_owner"}, bus.owner, r);
        n = 0;
        while (!bus.wr_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, bus.wr_done, 1);
        @(posedge clk); #1;
        chk({tag, "_ack"}, r ? bus.r1_ack : bus.r0_ack, 1);
        chk({tag, "_nack"}, r ? bus.r0_ack : bus.r1_ack, 0);
    endtask

    task automatic set_req(input logic r, input logic req, input logic rs,
                           input logic [7:0] d, input logic last);
        if (r) begin
            bus.r1_req = req; bus.r1_rs = rs; bus.r1_data = d; bus.r1_last = last;
        end else begin
            bus.r0_req = req; bus.r0_rs = rs; bus.r0_data = d; bus.r0_last = last;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ack0"}, bus.r0_ack, 0);
        chk({tag, "_ack1"}, bus.r1_ack, 0);
        chk({tag, "_start"}, bus.wr_start, 0);
        chk({tag, "_wr"}, {bus.wr_rs, bus.wr_data}, 9'h000);
        chk({tag, "_ready"}, bus.ready, 0);
        chk({tag, "_owner"}, bus.owner, 0);
    endtask

    initial begin
        int n;
        int s0;
        int acks;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        set_req(0, 0, 0, 8'h00, 0);
        set_req(1, 0, 0, 8'h00, 0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");

        // Power-up and init sequence
        reset = 1'b1;
        n = 0;
        while (!bus.wr_start && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_start_cyc", n, 20);
        n = 0;
        while (!(bus.wr_done && starts == 4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("init_4th_done", bus.wr_done, 1);
        @(posedge clk);
        n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_dly", n, 10);
        chk("init0", log_q[0], 9'h038);
        chk("init1", log_q[1], 9'h00C);
        chk("init2", log_q[2], 9'h006);
        chk("init3", log_q[3], 9'h001);

        // Single r0 data byte with latency check
        set_req(0, 1, 1, 8'h41, 1);
        @(posedge clk); #1;
        chk("lat_start", bus.wr_start, 1);
        chk("lat_ready", bus.ready, 0);
        serve(0, 1, 8'h41, "b41");
        @(posedge clk); #1;
        chk("b41_ack_1cyc", bus.r0_ack, 0);
        chk("b41_ready", bus.ready, 1);
        set_req(0, 0, 0, 8'h00, 0);

        // r1 alone: last_grant becomes r1
        set_req(1, 1, 1, 8'h42, 1);
        serve(1, 1, 8'h42, "b42");
        @(posedge clk); #1;
        set_req(1, 0, 0, 8'h00, 0);

        // Pair 1: r0 wins (last grant r1), then r1
        set_req(0, 1, 1, 8'h50, 1);
        set_req(1, 1, 1, 8'h51, 1);
        serve(0, 1, 8'h50, "pa0");
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'h00, 0);
        serve(1, 1, 8'h51, "pa1");
        @(posedge clk); #1;
        set_req(1, 0, 0, 8'h00, 0);

        // Lone r0 byte, then pair 2: r1 wins
        set_req(0, 1, 1, 8'h52, 1);
        serve(0, 1, 8'h52, "b52");
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'h00, 0);
        set_req(0, 1, 1, 8'h53, 1);
        set_req(1, 1, 1, 8'h54, 1);
        serve(1, 1, 8'h54, "pb1");
        @(posedge clk); #1;
        set_req(1, 0, 0, 8'h00, 0);
        serve(0, 1, 8'h53, "pb0");
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'h00, 0);

        // r1 three-byte packet; r0 requests after byte 1 and must wait
        set_req(1, 1, 1, 8'h61, 0);
        serve(1, 1, 8'h61, "pk1");
        @(posedge clk); #1;
        set_req(1, 1, 1, 8'h62, 0);
        set_req(0, 1, 1, 8'h70, 1);
        serve(1, 1, 8'h62, "pk2");
        @(posedge clk); #1;
        set_req(1, 1, 1, 8'h63, 1);
        serve(1, 1, 8'h63, "pk3");
        @(posedge clk); #1;
        set_req(1, 0, 0, 8'h00, 0);
        serve(0, 1, 8'h70, "pk_r0");
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'h00, 0);

        // Clear instruction: ack 10 cycles after wr_done, no starts meanwhile
        set_req(0, 1, 0, 8'h01, 1);
        n = 0;
        while (!bus.wr_start && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_byte", {bus.wr_rs, bus.wr_data}, 9'h001);
        n = 0;
        while (!bus.wr_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("clr_done", bus.wr_done, 1);
        @(posedge clk);
        s0 = starts;
        n = 0;
        while (!bus.r0_ack && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_ack_dly", n, 10);
        chk("clr_no_start", starts, s0);
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'h00, 0);

        // Reset while a data byte is in WAIT_DONE
        set_req(1, 1, 1, 8'h55, 1);
        n = 0;
        while (!bus.wr_start && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_start", {bus.wr_rs, bus.wr_data}, 9'h155);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outs("mid_rst");
        set_req(1, 0, 0, 8'h00, 0);
        reset = 1'b1;
        n = 0;
        acks = 0;
        while (!bus.wr_start && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.r0_ack || bus.r1_ack) acks++;
        end
        chk("re_start_cyc", n, 20);
        chk("re_no_ack", acks, 0);
        chk("re_init0", {bus.wr_rs, bus.wr_data}, 9'h038);
        n = 0;
        while (!bus.ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("re_ready", bus.ready, 1);

        chk("protocol_viol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
